// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment table for the multiplexed 7-segment driver.
// Segment order is {a,b,c,d,e,f,g} on bits [6:0], active-high before any polarity flip.
package seg7_pkg;

   typedef logic [6:0] seg7_t;

   localparam seg7_t SEG7_OFF = 7'b000_0000;

   localparam seg7_t SEG7_LUT [16] = '{
      7'b111_1110, 7'b011_0000, 7'b110_1101, 7'b111_1001,
      7'b011_0011, 7'b101_1011, 7'b101_1111, 7'b111_0000,
      7'b111_1111, 7'b111_1011, 7'b111_0111, 7'b001_1111,
      7'b100_1110, 7'b011_1101, 7'b100_1111, 7'b100_0111
   };

   // Applies the board's electrical polarity to an active-high pattern.
   function automatic seg7_t seg7_polar(input seg7_t seg, input bit act_low);
      return act_low ? ~seg : seg;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex digit to active-high segment pattern.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] digit_i,
   output seg7_t      seg_o
);

   // Table lookup; all 16 codes are defined so no fallback is needed.
   always_comb begin
      seg_o = SEG7_LUT[digit_i];
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit multiplexed hex display driver with frame-aligned double buffering.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int N_DIGITS     = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 2,
   parameter bit SEG_ACT_LOW  = 1'b0,
   parameter bit AN_ACT_LOW   = 1'b0
)
(
   input  logic                  w_clk,
   input  logic                  w_rst_n,
   input  logic [4*N_DIGITS-1:0] w_digits,
   input  logic                  w_load,
   input  logic [N_DIGITS-1:0]   w_blank_mask,
   output logic [6:0]            w_seg7,
   output logic [N_DIGITS-1:0]   w_an,
   output logic                  w_frame
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_BLANK = DIV_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);
   localparam seg7_t                SEG_OFF_V = seg7_polar(SEG7_OFF, SEG_ACT_LOW);
   localparam logic [N_DIGITS-1:0]  AN_OFF_V  = {N_DIGITS{AN_ACT_LOW}};

   logic [DIV_W-1:0]      div_q, div_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [4*N_DIGITS-1:0] active_q, active_d;
   logic [4*N_DIGITS-1:0] pending_q, pending_d;
   logic                  pend_flag_q, pend_flag_d;
   logic                  frame_q, frame_d;
   seg7_t                 seg_q, seg_d;
   logic [N_DIGITS-1:0]   an_q, an_d;

   logic                  boundary_s;
   logic [3:0]            cur_digit_s;
   logic                  mask_sel_s;
   logic                  lzb_sel_s;
   logic [N_DIGITS-1:0]   onehot_s;
   logic [N_DIGITS-1:0]   lzb_s;
   logic                  lit_s;
   seg7_t                 dec_seg_s;

   assign boundary_s = (div_q == DIV_LAST) && (idx_q == IDX_LAST);

   // Slot divider and digit index.
   always_comb begin
      div_d = div_q;
      idx_d = idx_q;
      if (div_q == DIV_LAST) begin
         div_d = '0;
         if (idx_q == IDX_LAST) begin
            idx_d = '0;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end else begin
         div_d = div_q + DIV_W'(1);
      end
   end

   // Double buffer: a load on the boundary itself bypasses pending so it shows next frame.
   always_comb begin
      active_d    = active_q;
      pending_d   = pending_q;
      pend_flag_d = pend_flag_q;
      if (w_load) begin
         pending_d = w_digits;
         if (boundary_s) begin
            active_d    = w_digits;
            pend_flag_d = 1'b0;
         end else begin
            pend_flag_d = 1'b1;
         end
      end else if (boundary_s && pend_flag_q) begin
         active_d    = pending_q;
         pend_flag_d = 1'b0;
      end else begin
         pend_flag_d = pend_flag_q;
      end
   end

`ifdef SEG7_LZB_EN
   logic zero_run_s;

   // A digit is blanked when it and every more significant digit are zero; digit 0 never is.
   always_comb begin
      zero_run_s = 1'b1;
      lzb_s      = '0;
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
         zero_run_s = zero_run_s && (active_q[4*k +: 4] == 4'h0);
         lzb_s[k]   = (k > 0) && zero_run_s;
      end
   end
`else
   // Leading-zero blanking compiled out.
   always_comb begin
      lzb_s = '0;
   end
`endif

   // Per-index selection of digit value, mask bit, blanking bit and anode.
   always_comb begin
      cur_digit_s = 4'h0;
      mask_sel_s  = 1'b0;
      lzb_sel_s   = 1'b0;
      onehot_s    = '0;
      for (int k = 0; k < N_DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            cur_digit_s = active_q[4*k +: 4];
            mask_sel_s  = w_blank_mask[k];
            lzb_sel_s   = lzb_s[k];
            onehot_s[k] = 1'b1;
         end else begin
            onehot_s[k] = 1'b0;
         end
      end
   end

   seg7_decode u_decode (
      .digit_i (cur_digit_s),
      .seg_o   (dec_seg_s)
   );

   assign lit_s = (div_q >= DIV_BLANK) && !mask_sel_s && !lzb_sel_s;

   // Output next-state with polarity applied after decode.
   always_comb begin
      frame_d = boundary_s;
      if (lit_s) begin
         seg_d = seg7_polar(dec_seg_s, SEG_ACT_LOW);
         an_d  = onehot_s ^ AN_OFF_V;
      end else begin
         seg_d = SEG_OFF_V;
         an_d  = AN_OFF_V;
      end
   end

   // State and output registers.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         div_q       <= '0;
         idx_q       <= '0;
         active_q    <= '0;
         pending_q   <= '0;
         pend_flag_q <= 1'b0;
         frame_q     <= 1'b0;
         seg_q       <= SEG_OFF_V;
         an_q        <= AN_OFF_V;
      end else begin
         div_q       <= div_d;
         idx_q       <= idx_d;
         active_q    <= active_d;
         pending_q   <= pending_d;
         pend_flag_q <= pend_flag_d;
         frame_q     <= frame_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
      end
   end

   assign w_seg7  = seg_q;
   assign w_an    = an_q;
   assign w_frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, 4 clocks/slot, 1 guard cycle, active-high).
module tb_seg7_scan_driver;

   logic        w_clk;
   logic        w_rst_n;
   logic [15:0] w_digits;
   logic        w_load;
   logic [3:0]  w_blank_mask;
   logic [6:0]  w_seg7;
   logic [3:0]  w_an;
   logic        w_frame;

   int n_checks;
   int n_errors;

   localparam logic [6:0] TB_LUT [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   seg7_scan_driver #(
      .N_DIGITS     (4),
      .SCAN_DIV     (4),
      .BLANK_CYCLES (1),
      .SEG_ACT_LOW  (1'b0),
      .AN_ACT_LOW   (1'b0)
   ) dut (
      .w_clk        (w_clk),
      .w_rst_n      (w_rst_n),
      .w_digits     (w_digits),
      .w_load       (w_load),
      .w_blank_mask (w_blank_mask),
      .w_seg7       (w_seg7),
      .w_an         (w_an),
      .w_frame      (w_frame)
   );

   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;

   // Expected-value model: scan state st = idx*4 + div.
   function automatic logic [3:0] dig(input logic [15:0] d, input int k);
      logic [15:0] t;
      t = d >> (4 * k);
      return t[3:0];
   endfunction

   function automatic logic m_lzb(input logic [15:0] d, input int k);
`ifdef SEG7_LZB_EN
      logic z;
      z = 1'b1;
      for (int i = 3; i >= k; i--) begin
         if (dig(d, i) != 4'h0) z = 1'b0;
      end
      return (k > 0) && z;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic m_lit(input int st, input logic [15:0] d, input logic [3:0] mask);
      int idx;
      int dv;
      idx = st / 4;
      dv  = st % 4;
      return (dv >= 1) && !mask[idx] && !m_lzb(d, idx);
   endfunction

   function automatic logic [3:0] m_an(input int st, input logic [15:0] d, input logic [3:0] mask);
      return m_lit(st, d, mask) ? (4'b0001 << (st / 4)) : 4'b0000;
   endfunction

   function automatic logic [6:0] m_seg(input int st, input logic [15:0] d, input logic [3:0] mask);
      return m_lit(st, d, mask) ? TB_LUT[dig(d, st / 4)] : 7'b0000000;
   endfunction

   task automatic wait_frame(input string tag);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge w_clk);
         if (w_frame === 1'b1) found = 1'b1;
      end
      n_checks++;
      if (!found) begin
         n_errors++;
         $display("FAIL %s frame_timeout got no w_frame pulse within 40 clocks", tag);
      end
   endtask

   task automatic test_reset();
      w_rst_n = 1'b0; w_load = 1'b0; w_digits = 16'h0000; w_blank_mask = 4'b0000;
      repeat (3) @(negedge w_clk);
      n_checks++;
      if (w_an !== 4'b0000 || w_seg7 !== 7'b0000000 || w_frame !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_state got an=%b seg=%b frame=%b exp an=0000 seg=0000000 frame=0", w_an, w_seg7, w_frame);
      end
      w_rst_n = 1'b1;
      @(negedge w_clk);
      n_checks++;
      if (w_an !== 4'b0000) begin
         n_errors++;
         $display("FAIL reset_guard got an=%b exp 0000", w_an);
      end
      @(negedge w_clk);
      n_checks++;
      if (w_an !== 4'b0001 || w_seg7 !== 7'b1111110) begin
         n_errors++;
         $display("FAIL reset_first_lit got an=%b seg=%b exp an=0001 seg=1111110", w_an, w_seg7);
      end
   endtask

   task automatic test_decode();
      w_digits = 16'h12AF; w_load = 1'b1;
      @(negedge w_clk);
      w_load = 1'b0;
      wait_frame("decode");
      for (int j = 1; j <= 16; j++) begin
         @(negedge w_clk);
         n_checks += 3;
         if (w_an !== m_an(j-1, 16'h12AF, 4'b0000)) begin
            n_errors++; $display("FAIL decode_an st=%0d got %b exp %b", j-1, w_an, m_an(j-1, 16'h12AF, 4'b0000));
         end
         if (w_seg7 !== m_seg(j-1, 16'h12AF, 4'b0000)) begin
            n_errors++; $display("FAIL decode_seg st=%0d got %b exp %b", j-1, w_seg7, m_seg(j-1, 16'h12AF, 4'b0000));
         end
         if (w_frame !== (j == 16)) begin
            n_errors++; $display("FAIL decode_frame st=%0d got %b exp %b", j-1, w_frame, (j == 16));
         end
      end
   endtask

   task automatic test_blank_mask();
      logic [3:0] seen;
      seen = 4'b0000;
      w_blank_mask = 4'b0100;
      for (int j = 1; j <= 16; j++) begin
         @(negedge w_clk);
         seen |= w_an;
         n_checks += 2;
         if (w_an !== m_an(j-1, 16'h12AF, 4'b0100)) begin
            n_errors++; $display("FAIL mask_an st=%0d got %b exp %b", j-1, w_an, m_an(j-1, 16'h12AF, 4'b0100));
         end
         if (w_seg7 !== m_seg(j-1, 16'h12AF, 4'b0100)) begin
            n_errors++; $display("FAIL mask_seg st=%0d got %b exp %b", j-1, w_seg7, m_seg(j-1, 16'h12AF, 4'b0100));
         end
      end
      n_checks++;
      if (seen !== 4'b1011) begin
         n_errors++; $display("FAIL mask_digits_lit got %b exp 1011", seen);
      end
      w_blank_mask = 4'b0000;
   endtask

   task automatic test_double_buffer();
      for (int j = 1; j <= 16; j++) begin
         @(negedge w_clk);
         n_checks += 3;
         if (w_an !== m_an(j-1, 16'h12AF, 4'b0000)) begin
            n_errors++; $display("FAIL dbuf_old_an st=%0d got %b exp %b", j-1, w_an, m_an(j-1, 16'h12AF, 4'b0000));
         end
         if (w_seg7 !== m_seg(j-1, 16'h12AF, 4'b0000)) begin
            n_errors++; $display("FAIL dbuf_old_seg st=%0d got %b exp %b", j-1, w_seg7, m_seg(j-1, 16'h12AF, 4'b0000));
         end
         if (w_frame !== (j == 16)) begin
            n_errors++; $display("FAIL dbuf_frame st=%0d got %b exp %b", j-1, w_frame, (j == 16));
         end
         if (j == 2) begin w_digits = 16'h5555; w_load = 1'b1; end
         else if (j == 5) begin w_digits = 16'h0000; w_load = 1'b1; end
         else w_load = 1'b0;
      end
      for (int j = 1; j <= 16; j++) begin
         @(negedge w_clk);
         n_checks += 3;
         if (w_an !== m_an(j-1, 16'h0000, 4'b0000)) begin
            n_errors++; $display("FAIL dbuf_new_an st=%0d got %b exp %b", j-1, w_an, m_an(j-1, 16'h0000, 4'b0000));
         end
         if (w_seg7 !== m_seg(j-1, 16'h0000, 4'b0000)) begin
            n_errors++; $display("FAIL dbuf_new_seg st=%0d got %b exp %b", j-1, w_seg7, m_seg(j-1, 16'h0000, 4'b0000));
         end
         if (w_frame !== (j == 16)) begin
            n_errors++; $display("FAIL dbuf_frame2 st=%0d got %b exp %b", j-1, w_frame, (j == 16));
         end
      end
   endtask

   task automatic test_lzb();
      logic [15:0] vals [3];
      logic [3:0]  seen;
      logic [3:0]  exp_seen;
      vals[0] = 16'h0000; vals[1] = 16'h0030; vals[2] = 16'h0000;
      for (int f = 0; f < 3; f++) begin
         seen = 4'b0000;
         for (int j = 1; j <= 16; j++) begin
            @(negedge w_clk);
            seen |= w_an;
            n_checks += 2;
            if (w_an !== m_an(j-1, vals[f], 4'b0000)) begin
               n_errors++; $display("FAIL lzb_an f=%0d st=%0d got %b exp %b", f, j-1, w_an, m_an(j-1, vals[f], 4'b0000));
            end
            if (w_seg7 !== m_seg(j-1, vals[f], 4'b0000)) begin
               n_errors++; $display("FAIL lzb_seg f=%0d st=%0d got %b exp %b", f, j-1, w_seg7, m_seg(j-1, vals[f], 4'b0000));
            end
            if (j == 1 && f < 2) begin w_digits = vals[f+1]; w_load = 1'b1; end
            else w_load = 1'b0;
         end
`ifdef SEG7_LZB_EN
         exp_seen = (vals[f] == 16'h0030) ? 4'b0011 : 4'b0001;
`else
         exp_seen = 4'b1111;
`endif
         n_checks++;
         if (seen !== exp_seen) begin
            n_errors++; $display("FAIL lzb_digits_lit f=%0d got %b exp %b", f, seen, exp_seen);
         end
      end
   endtask

   task automatic test_async_reset();
      w_digits = 16'h4321; w_load = 1'b1;
      for (int j = 1; j <= 16; j++) begin
         @(negedge w_clk);
         w_load = 1'b0;
      end
      for (int j = 1; j <= 10; j++) begin
         @(negedge w_clk);
         n_checks++;
         if (w_an !== m_an(j-1, 16'h4321, 4'b0000)) begin
            n_errors++; $display("FAIL arst_pre_an st=%0d got %b exp %b", j-1, w_an, m_an(j-1, 16'h4321, 4'b0000));
         end
         if (j == 9) begin w_digits = 16'h9999; w_load = 1'b1; end
         else w_load = 1'b0;
      end
      n_checks++;
      if (w_seg7 !== 7'b1111001) begin
         n_errors++; $display("FAIL arst_pre_seg got %b exp 1111001", w_seg7);
      end
      #2 w_rst_n = 1'b0;
      #1;
      n_checks++;
      if (w_an !== 4'b0000 || w_seg7 !== 7'b0000000 || w_frame !== 1'b0) begin
         n_errors++; $display("FAIL arst_immediate got an=%b seg=%b frame=%b exp all off", w_an, w_seg7, w_frame);
      end
      @(negedge w_clk);
      w_rst_n = 1'b1;
      for (int j = 1; j <= 16; j++) begin
         @(negedge w_clk);
         n_checks += 3;
         if (w_an !== m_an(j-1, 16'h0000, 4'b0000)) begin
            n_errors++; $display("FAIL arst_restart_an st=%0d got %b exp %b", j-1, w_an, m_an(j-1, 16'h0000, 4'b0000));
         end
         if (w_seg7 !== m_seg(j-1, 16'h0000, 4'b0000)) begin
            n_errors++; $display("FAIL arst_restart_seg st=%0d got %b exp %b", j-1, w_seg7, m_seg(j-1, 16'h0000, 4'b0000));
         end
         if (w_frame !== (j == 16)) begin
            n_errors++; $display("FAIL arst_restart_frame st=%0d got %b exp %b", j-1, w_frame, (j == 16));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] vals [2];
      vals[0] = 16'h0000; vals[1] = 16'hBE3F;
      for (int f = 0; f < 2; f++) begin
         for (int j = 1; j <= 16; j++) begin
            @(negedge w_clk);
            n_checks += 2;
            if (w_an !== m_an(j-1, vals[f], 4'b0000)) begin
               n_errors++; $display("FAIL b2b_an f=%0d st=%0d got %b exp %b", f, j-1, w_an, m_an(j-1, vals[f], 4'b0000));
            end
            if (w_seg7 !== m_seg(j-1, vals[f], 4'b0000)) begin
               n_errors++; $display("FAIL b2b_seg f=%0d st=%0d got %b exp %b", f, j-1, w_seg7, m_seg(j-1, vals[f], 4'b0000));
            end
            if (j == 15 && f == 0) begin w_digits = 16'hBE3F; w_load = 1'b1; end
            else w_load = 1'b0;
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset();
      test_decode();
      test_blank_mask();
      test_double_buffer();
      test_lzb();
      test_async_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
